reject_sampler_core: RTL and testbench

//  Per-lane parallel rejection sampler for Kyber-style polynomial sampling.

---
 rtl/reject_sampler_core.sv | 120 ++++++++++++
 tb/tb_reject_sampler_core.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reject_sampler_core.sv
// Per-lane parallel rejection sampler: mode 0 tests random_in slices against q, mode 1 tests urnd < threshold.
// Define REJECT_SAMPLER_ACC_CNT_EN to add acc_count, a running total of accepted lanes.
module reject_sampler_core #(
   parameter int unsigned LANES      = 4,
   parameter int unsigned CAND_BITS  = 12,
   parameter bit          CONST_TIME = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         random_valid,
   input  logic [127:0]                 random_in,
   input  logic [15:0]                  q,
   input  logic [LANES*CAND_BITS-1:0]   cand_bus,
   input  logic [LANES*CAND_BITS-1:0]   urnd_bus,
   input  logic [LANES*CAND_BITS-1:0]   threshold_bus,
   input  logic [LANES-1:0]             mode_select,
   output logic [LANES-1:0]             acc_bus,
   output logic [LANES*CAND_BITS-1:0]   sample_tdata,
   output logic                         sample_tvalid
`ifdef REJECT_SAMPLER_ACC_CNT_EN
   ,
   output logic [31:0]                  acc_count
`endif
);

   localparam int unsigned BUS_W  = LANES * CAND_BITS;
   localparam int unsigned CMP_W  = (CAND_BITS > 16) ? CAND_BITS : 16;
   localparam int unsigned SLOT_W = $clog2(LANES + 1);

   if (BUS_W > 128 || LANES == 0 || CAND_BITS == 0) begin : g_bad_cfg
      $error("reject_sampler_core: LANES*CAND_BITS must be in 1..128");
   end

   if (BUS_W < 128) begin : g_spare_entropy
      logic unused_entropy;
      assign unused_entropy = ^random_in[127:BUS_W];
   end

   logic [LANES-1:0] accept;
   logic [BUS_W-1:0] positional;
   logic [BUS_W-1:0] data_next;
   logic             valid_next;

   // Lane evaluation is pure compare + mux, so every lane takes the same path regardless of data.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [CAND_BITS-1:0] cand0;
      logic [CAND_BITS-1:0] cand1;
      logic [CAND_BITS-1:0] urnd;
      logic [CAND_BITS-1:0] thr;
      logic                 ok0;
      logic                 ok1;

      assign cand0 = random_in[i*CAND_BITS +: CAND_BITS];
      assign cand1 = cand_bus[i*CAND_BITS +: CAND_BITS];
      assign urnd  = urnd_bus[i*CAND_BITS +: CAND_BITS];
      assign thr   = threshold_bus[i*CAND_BITS +: CAND_BITS];
      assign ok0   = CMP_W'(cand0) < CMP_W'(q);
      assign ok1   = urnd < thr;

      assign accept[i] = random_valid & (mode_select[i] ? ok1 : ok0);
      assign positional[i*CAND_BITS +: CAND_BITS] =
         accept[i] ? (mode_select[i] ? cand1 : cand0) : '0;
   end

   if (CONST_TIME) begin : g_const_time
      assign data_next  = positional;
      assign valid_next = random_valid;
   end else begin : g_compact
      logic [BUS_W-1:0]  compact;
      logic [SLOT_W-1:0] slot;

      // Pack accepted lanes toward lane 0 in ascending lane order.
      always_comb begin
         compact = '0;
         slot    = '0;
         for (int i = 0; i < LANES; i++) begin
            if (accept[i]) begin
               compact[slot*CAND_BITS +: CAND_BITS] = positional[i*CAND_BITS +: CAND_BITS];
               slot = slot + SLOT_W'(1);
            end
         end
      end

      assign data_next  = compact;
      assign valid_next = |accept;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_bus       <= '0;
         sample_tdata  <= '0;
         sample_tvalid <= 1'b0;
      end else begin
         acc_bus       <= accept;
         sample_tdata  <= data_next;
         sample_tvalid <= valid_next;
      end
   end

`ifdef REJECT_SAMPLER_ACC_CNT_EN
   logic [31:0] pop;

   always_comb begin
      pop = '0;
      for (int i = 0; i < LANES; i++) begin
         pop = pop + 32'(accept[i]);
      end
   end

   // Wraps modulo 2^32 by construction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_count <= '0;
      end else begin
         acc_count <= acc_count + pop;
      end
   end
`endif

endmodule

// File: tb/tb_reject_sampler_core.sv
// Scoreboard bench for reject_sampler_core: one positional (CONST_TIME=1) and one compacting (CONST_TIME=0) instance share stimulus.
// Directed vectors carry hand-computed expectations; the back-to-back phase uses a small golden model.
module tb_reject_sampler_core;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         random_valid;
   logic [127:0] random_in;
   logic [15:0]  q;
   logic [47:0]  cand_bus;
   logic [47:0]  urnd_bus;
   logic [47:0]  threshold_bus;
   logic [3:0]   mode_select;

   logic [3:0]   acc_ct;
   logic [47:0]  tdata_ct;
   logic         tvalid_ct;
   logic [3:0]   acc_cmp;
   logic [47:0]  tdata_cmp;
   logic         tvalid_cmp;
`ifdef REJECT_SAMPLER_ACC_CNT_EN
   logic [31:0]  cnt_ct;
   logic [31:0]  cnt_cmp;
`endif

   always #5 clk = ~clk;

   reject_sampler_core #(.LANES(4), .CAND_BITS(12), .CONST_TIME(1'b1)) u_ct (
      .clk           (clk),
      .rst_n         (rst_n),
      .random_valid  (random_valid),
      .random_in     (random_in),
      .q             (q),
      .cand_bus      (cand_bus),
      .urnd_bus      (urnd_bus),
      .threshold_bus (threshold_bus),
      .mode_select   (mode_select),
      .acc_bus       (acc_ct),
      .sample_tdata  (tdata_ct),
      .sample_tvalid (tvalid_ct)
`ifdef REJECT_SAMPLER_ACC_CNT_EN
      ,
      .acc_count     (cnt_ct)
`endif
   );

   reject_sampler_core #(.LANES(4), .CAND_BITS(12), .CONST_TIME(1'b0)) u_cmp (
      .clk           (clk),
      .rst_n         (rst_n),
      .random_valid  (random_valid),
      .random_in     (random_in),
      .q             (q),
      .cand_bus      (cand_bus),
      .urnd_bus      (urnd_bus),
      .threshold_bus (threshold_bus),
      .mode_select   (mode_select),
      .acc_bus       (acc_cmp),
      .sample_tdata  (tdata_cmp),
      .sample_tvalid (tvalid_cmp)
`ifdef REJECT_SAMPLER_ACC_CNT_EN
      ,
      .acc_count     (cnt_cmp)
`endif
   );

   typedef struct {
      string       name;
      logic [3:0]  acc;
      logic [47:0] d_ct;
      logic        v_ct;
      logic [47:0] d_cmp;
      logic        v_cmp;
      logic [31:0] cnt;
   } exp_t;

   exp_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] model_cnt = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, want);
      end
   endtask

   // Monitor: one expected record per clock, compared on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.name, ".acc_ct"},    64'(acc_ct),     64'(e.acc));
            chk({e.name, ".acc_cmp"},   64'(acc_cmp),    64'(e.acc));
            chk({e.name, ".tdata_ct"},  64'(tdata_ct),   64'(e.d_ct));
            chk({e.name, ".tvalid_ct"}, 64'(tvalid_ct),  64'(e.v_ct));
            chk({e.name, ".tdata_cmp"}, 64'(tdata_cmp),  64'(e.d_cmp));
            chk({e.name, ".tvalid_cmp"},64'(tvalid_cmp), 64'(e.v_cmp));
`ifdef REJECT_SAMPLER_ACC_CNT_EN
            chk({e.name, ".cnt_ct"},    64'(cnt_ct),     64'(e.cnt));
            chk({e.name, ".cnt_cmp"},   64'(cnt_cmp),    64'(e.cnt));
`endif
         end
      end
   end

   // Clock in the current inputs and queue what must appear after this edge.
   task automatic issue(input exp_t e);
      @(posedge clk);
      if (!rst_n) model_cnt = '0;
      else model_cnt = model_cnt + 32'($countones(e.acc));
      e.cnt = model_cnt;
      exp_q.push_back(e);
      #1;
   endtask

   task automatic issue_hand(input string nm, input logic [3:0] acc,
                             input logic [47:0] d_ct, input logic v_ct,
                             input logic [47:0] d_cmp, input logic v_cmp);
      exp_t e;
      e.name = nm; e.acc = acc; e.d_ct = d_ct; e.v_ct = v_ct;
      e.d_cmp = d_cmp; e.v_cmp = v_cmp; e.cnt = '0;
      issue(e);
   endtask

   function automatic exp_t golden(input string nm);
      exp_t        e;
      int          slot;
      logic        ok;
      logic [11:0] s;
      e.name = nm; e.acc = '0; e.d_ct = '0; e.d_cmp = '0; e.cnt = '0;
      slot = 0;
      for (int i = 0; i < 4; i++) begin
         if (mode_select[i]) begin
            ok = urnd_bus[i*12 +: 12] < threshold_bus[i*12 +: 12];
            s  = cand_bus[i*12 +: 12];
         end else begin
            ok = {4'b0000, random_in[i*12 +: 12]} < q;
            s  = random_in[i*12 +: 12];
         end
         ok = ok & random_valid & rst_n;
         e.acc[i] = ok;
         if (ok) begin
            e.d_ct[i*12 +: 12]     = s;
            e.d_cmp[slot*12 +: 12] = s;
            slot++;
         end
      end
      e.v_ct  = random_valid & rst_n;
      e.v_cmp = |e.acc;
      return e;
   endfunction

   task automatic set_in(input logic v, input logic [15:0] qq, input logic [3:0] m,
                         input logic [47:0] r48, input logic [47:0] cb,
                         input logic [47:0] ub, input logic [47:0] tb);
      random_in       = {$urandom(), $urandom(), $urandom(), $urandom()};
      random_in[47:0] = r48;
      random_valid    = v;
      q               = qq;
      mode_select     = m;
      cand_bus        = cb;
      urnd_bus        = ub;
      threshold_bus   = tb;
   endtask

   function automatic logic [47:0] rnd48();
      return {16'($urandom()), $urandom()};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [15:0] qr;
      int          drain;
      rst_n = 1'b0;
      set_in(1'b1, 16'd3329, 4'($urandom()), rnd48(), rnd48(), rnd48(), rnd48());
      #1;

      for (int i = 0; i < 3; i++) begin
         set_in(1'b1, 16'($urandom()), 4'($urandom()), rnd48(), rnd48(), rnd48(), rnd48());
         issue_hand("reset", 4'b0, 48'h0, 1'b0, 48'h0, 1'b0);
      end
      rst_n = 1'b1;

      set_in(1'b1, 16'd3329, 4'b0000, 48'hFFF_D01_D00_000, rnd48(), rnd48(), rnd48());
      issue_hand("mode0", 4'b0011, 48'h000_000_D00_000, 1'b1, 48'h000_000_D00_000, 1'b1);

      set_in(1'b1, 16'd3329, 4'b1111, rnd48(), 48'hAAA_BBB_CCC_DDD,
             {12'd40, 12'd30, 12'd20, 12'd10}, {4{12'd25}});
      issue_hand("mode1", 4'b0011, 48'h000_000_CCC_DDD, 1'b1, 48'h000_000_CCC_DDD, 1'b1);

      set_in(1'b0, 16'd3329, 4'b0000, 48'hFFF_D01_D00_000, rnd48(), rnd48(), rnd48());
      issue_hand("invalid", 4'b0, 48'h0, 1'b0, 48'h0, 1'b0);

      set_in(1'b1, 16'd0, 4'b0000, 48'hFFF_D01_D00_000, rnd48(), rnd48(), rnd48());
      issue_hand("q_zero", 4'b0, 48'h0, 1'b1, 48'h0, 1'b0);

      set_in(1'b1, 16'd3329, 4'b0000, 48'h005_FFF_007_FFF, rnd48(), rnd48(), rnd48());
      issue_hand("compact", 4'b1010, 48'h005_000_007_000, 1'b1, 48'h000_000_005_007, 1'b1);

      set_in(1'b1, 16'd3329, 4'b0000, 48'hFFF_FFF_FFF_FFF, rnd48(), rnd48(), rnd48());
      issue_hand("all_reject", 4'b0, 48'h0, 1'b1, 48'h0, 1'b0);

      // Lane 0 threshold 0 rejects, lane 2 threshold accepts, lanes 1/3 uniform accept.
      set_in(1'b1, 16'd3329, 4'b0101, 48'h100_E00_200_D01, 48'h444_123_222_111,
             {12'd9, 12'd7, 12'd9, 12'd5}, {12'd1, 12'd8, 12'd1, 12'd0});
      issue_hand("mixed", 4'b1110, 48'h100_123_200_000, 1'b1, 48'h000_100_123_200, 1'b1);

      set_in(1'b1, 16'h1000, 4'b0000, 48'hFFF_ABC_001_000, rnd48(), rnd48(), rnd48());
      issue_hand("q_4096", 4'b1111, 48'hFFF_ABC_001_000, 1'b1, 48'hFFF_ABC_001_000, 1'b1);

      for (int n = 0; n < 80; n++) begin
         case ($urandom_range(0, 3))
            0:       qr = 16'd3329;
            1:       qr = 16'($urandom_range(0, 5000));
            2:       qr = 16'($urandom());
            default: qr = 16'd0;
         endcase
         set_in($urandom_range(0, 7) != 0, qr, 4'($urandom()), rnd48(), rnd48(), rnd48(), rnd48());
         issue(golden("b2b"));
      end
      for (int n = 0; n < 5; n++) begin
         set_in(1'b0, 16'd3329, 4'($urandom()), rnd48(), rnd48(), rnd48(), rnd48());
         issue(golden("flush"));
      end

      // A reset mid-stream drops the in-flight vector and clears the count.
      rst_n = 1'b0;
      set_in(1'b1, 16'h1000, 4'b0000, rnd48(), rnd48(), rnd48(), rnd48());
      issue(golden("mid_reset"));
      rst_n = 1'b1;
      set_in(1'b1, 16'h1000, 4'b0000, 48'h123_456_789_ABC, rnd48(), rnd48(), rnd48());
      issue_hand("after_reset", 4'b1111, 48'h123_456_789_ABC, 1'b1, 48'h123_456_789_ABC, 1'b1);
      set_in(1'b0, 16'd0, 4'b0000, rnd48(), rnd48(), rnd48(), rnd48());

      drain = 0;
      while (exp_q.size() > 0 && drain < 20) begin
         @(negedge clk);
         drain++;
      end
      #1;
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain actual=%0d_pending expected=0_pending", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
